if_fetch_resp: RTL
==================

IF_FETCH_RESP -- requirements
Module: if_fetch_resp

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles in WAIT before fetch abort; 8-bit range, 1..255.
REQ-002 Parameter NOP_INST, default 32'h00000013: instruction presented when no valid fetch is held.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 IF_PC  input  20  fetch byte address from the PC register.
REQ-006 mem_req  output  1  instruction-memory request valid.
REQ-007 mem_addr  output  18  word address of request (IF_PC[19:2] latched at request).
REQ-008 mem_gnt  input  1  memory accepts request when high with mem_req.
REQ-009 mem_rvalid  input  1  read data valid, one pulse per granted request.
REQ-010 mem_rdata  input  32  read data, qualified by mem_rvalid.
REQ-011 IF_inst  output  32  instruction for IF/ID stage.
REQ-012 IF_valid  output  1  IF_inst corresponds to current IF_PC.
REQ-013 fetch_stall  output  1  high when IF_PC is aligned and not yet served; hazard unit drops PCWrite on it.
REQ-014 misalign  output  1  IF_PC[1:0] != 0.
REQ-015 fetch_err  output  1  one-cycle pulse on fetch timeout.

Function
REQ-016 Block SHALL hold one-entry tagged buffer: buf_valid, buf_tag[17:0], buf_data[31:0].
REQ-017 hit SHALL be combinational: buf_valid && buf_tag == IF_PC[19:2] && IF_PC[1:0] == 0.
REQ-018 IF_valid = hit; IF_inst = hit ? buf_data : NOP_INST; misalign = (IF_PC[1:0] != 0); fetch_stall = !hit && !misalign.
REQ-019 FSM states IDLE, REQ, WAIT; encoding free.
REQ-020 IDLE: if !hit and !misalign at edge, latch req_tag = IF_PC[19:2], go REQ; else stay IDLE.
REQ-021 REQ: mem_req = 1, mem_addr = req_tag; mem_addr SHALL remain stable while mem_req high even if IF_PC changes; on mem_gnt at edge go WAIT, clear wait counter.
REQ-022 mem_req SHALL be low in IDLE and WAIT; mem_addr SHALL equal req_tag in all states.
REQ-023 WAIT: on mem_rvalid at edge write buf_data = mem_rdata, buf_tag = req_tag, buf_valid = 1, go IDLE.
REQ-024 WAIT: without mem_rvalid, increment wait counter; when counter reaches TIMEOUT without mem_rvalid, go IDLE, pulse fetch_err for exactly one cycle, buffer unchanged.
REQ-025 mem_rvalid outside WAIT SHALL be ignored.
REQ-026 Stale response: if IF_PC changed during REQ/WAIT, response is still written with req_tag; hit compare rejects it and IDLE issues a new request next edge.
REQ-027 Minimum miss latency: IF_PC miss seen at edge N -> mem_req high cycle N+1; gnt at edge N+1, rvalid at edge N+2 -> IF_valid high in cycle N+3.
REQ-028 Misaligned IF_PC SHALL issue no request; fetch_stall = 0, IF_valid = 0 so the trap path proceeds.
REQ-029 Same-tag refetch SHALL NOT occur while hit holds; sequential PCs each miss once.

Reset
REQ-030 reset_n low SHALL immediately force: state IDLE, buf_valid 0, buf_tag 0, buf_data NOP_INST, req_tag 0, wait counter 0, fetch_err 0, mem_req 0.
REQ-031 Reset asserted in REQ or WAIT SHALL abandon the transaction; any later mem_rvalid outside WAIT is ignored per REQ-025.
REQ-032 First request after reset release SHALL issue at the first edge with reset_n high and IF_PC aligned.

Verification
REQ-033 Reset release, IF_PC=0x00000, gnt same cycle, rvalid next cycle with 0x00500093 -> mem_addr=0, IF_valid=1, IF_inst=0x00500093 in 3rd cycle after release, fetch_stall then 0.
REQ-034 Hit held: IF_PC stays 0x00000 ten cycles after fill -> mem_req stays 0, IF_valid=1 throughout.
REQ-035 gnt delayed 4 cycles, IF_PC changes 0x00004->0x00010 during REQ -> mem_addr holds 0x00001 until gnt; after response, new request with mem_addr=0x00004; IF_valid only when data for 0x00010 arrives.
REQ-036 TIMEOUT=8, no mem_rvalid after gnt -> fetch_err pulses one cycle 8 cycles after entering WAIT, IF_inst=NOP_INST, request reissued.
REQ-037 IF_PC=0x00006 -> misalign=1, fetch_stall=0, IF_valid=0, no mem_req.
REQ-038 reset_n low mid-WAIT, then rvalid pulse -> buffer not written, IF_inst=0x00000013, mem_req 0 until reset release.

Source files
------------

// File: rtl/if_fetch_resp_if.sv
// Instruction-memory request/response bus between the fetch unit and the
// instruction memory. The fetch unit is the master.
interface if_fetch_resp_if;
  logic        mem_req;
  logic [17:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/if_fetch_resp.sv
// Fetch response unit: a one-entry tagged instruction buffer, refilled from
// instruction memory by an IDLE/REQ/WAIT request FSM with a response timeout.
module if_fetch_resp #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [19:0]            IF_PC,
  if_fetch_resp_if.master        mem,
  output logic [31:0]            IF_inst,
  output logic                   IF_valid,
  output logic                   fetch_stall,
  output logic                   misalign,
  output logic                   fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  // Last WAIT count before abort; WAIT therefore lasts exactly TIMEOUT cycles.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        buf_valid;
  logic [17:0] buf_tag;
  logic [31:0] buf_data;
  logic [17:0] req_tag;
  logic [7:0]  wait_cnt;
  logic        mem_req_q;
  logic        hit;

  assign misalign    = (IF_PC[1:0] != 2'b00);
  assign hit         = buf_valid && (buf_tag == IF_PC[19:2]) && !misalign;
  assign IF_valid    = hit;
  assign IF_inst     = hit ? buf_data : NOP_INST;
  assign fetch_stall = !hit && !misalign;

  // mem_addr comes from req_tag, so it stays put while a request is pending
  // regardless of what the PC does.
  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = req_tag;

  // NOTE: the single-entry data buffer is reset like any other register so a
  // fresh core sees NOP_INST rather than X; a deep RAM would not be reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= NOP_INST;
      req_tag   <= '0;
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
      mem_req_q <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch reads pre-edge values.
      fetch_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!hit && !misalign) begin
            req_tag   <= IF_PC[19:2];
            mem_req_q <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem.mem_gnt) begin
            mem_req_q <= 1'b0;
            wait_cnt  <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response is written under req_tag even if the PC moved on; the
          // hit compare then rejects it and IDLE refetches.
          if (mem.mem_rvalid) begin
            buf_valid <= 1'b1;
            buf_tag   <= req_tag;
            buf_data  <= mem.mem_rdata;
            state     <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == WAIT_LAST) begin
              fetch_err <= 1'b1;
              state     <= S_IDLE;
            end
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
